cp2_mac_unit: RTL and testbench

Coprocessor-2 responder for the pipeline's CP2 transfer signals. It accepts transfer-to (ts) operand pushes, accumulate-start (as) commands and transfer-from (fs) reads from the MEM stage. It runs an iterative 32×32 shift-add multiply-accumulate and drives `cp2_fdata_0` back to the ID-stage forwarding path. The block is the CP2 end of the `cp2_ts/as/fs` interface that the ID stage decodes and forwards.

---
 rtl/cp2_mac_unit_if.sv | 33 +++
 rtl/cp2_mac_unit.sv | 198 +++++++++++++++++++
 tb/tb_cp2_mac_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cp2_mac_unit_if.sv
// CP2 transfer bus between the MEM stage (master) and the CP2 MAC responder (slave).
// Carries the ts/as/fs commands and the forwarding/status signals returned by CP2.
interface cp2_mac_unit_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          mem_en;
    logic          stall;
    logic          mem_cp2_ts_0;
    logic          mem_cp2_as_0;
    logic          mem_cp2_fs_0;
    logic [31:0]   mem_cp2_wr_data;
    logic          cp_irenable_0;
    logic [31:0]   cp2_fdata_0;
    logic          cp2_busy;
    logic          cp2_irq;
    logic [CW-1:0] cp2_count;
    logic          cp2_ovf;
    logic          cp2_err;

    modport master (
        output mem_en, stall, mem_cp2_ts_0, mem_cp2_as_0, mem_cp2_fs_0,
        output mem_cp2_wr_data, cp_irenable_0,
        input  cp2_fdata_0, cp2_busy, cp2_irq, cp2_count, cp2_ovf, cp2_err
    );

    modport slave (
        input  mem_en, stall, mem_cp2_ts_0, mem_cp2_as_0, mem_cp2_fs_0,
        input  mem_cp2_wr_data, cp_irenable_0,
        output cp2_fdata_0, cp2_busy, cp2_irq, cp2_count, cp2_ovf, cp2_err
    );
endinterface

// File: rtl/cp2_mac_unit.sv
// CP2 responder: operand FIFO fed by ts pushes, iterative shift-add 32x32 MAC
// started by as commands, accumulator forwarded to the ID stage via cp2_fdata_0.
module cp2_mac_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_CYCLES = 32
) (
    input  logic          clk,
    input  logic          reset,
    cp2_mac_unit_if.slave cp2
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW-1:0] PTR_TWO    = PW'(2);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_TWO    = CW'(2);
    localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] ITER_ONE   = IW'(1);
    localparam logic [IW-1:0] ITER_LAST  = IW'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;

    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   acc_r;
    logic [31:0]   product_r;
    logic [31:0]   a_sh_r;
    logic [31:0]   b_sh_r;
    logic [IW-1:0] iter_r;
    logic          ovf_r;
    logic          err_r;
    logic          irq_r;

    logic          busy_s;
    logic          cmd_ok_s;
    logic          as_ok_s;
    logic          ts_ok_s;
    logic          push_s;
    logic          ovf_set_s;
    logic          mac_start_s;
    logic          err_set_s;
    logic          acc_clr_s;
    logic          flush_s;
    logic          acc_load_s;
    logic [31:0]   partial_s;

    // busy only ever blocks as/fs; ts is accepted whatever the FSM is doing
    assign busy_s    = cp2.mem_en & (cp2.mem_cp2_as_0 | cp2.mem_cp2_fs_0) & (state_r != ST_IDLE);
    assign cmd_ok_s  = cp2.mem_en & ~cp2.stall & ~busy_s;
    assign as_ok_s   = cmd_ok_s & cp2.mem_cp2_as_0;
    assign ts_ok_s   = cmd_ok_s & ~cp2.mem_cp2_as_0 & cp2.mem_cp2_ts_0;
    assign push_s    = ts_ok_s & (count_r < CNT_FULL);
    assign ovf_set_s = ts_ok_s & (count_r >= CNT_FULL);
    assign partial_s = b_sh_r[0] ? a_sh_r : 32'd0;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and command decode
    always_comb begin
        state_next_s = state_r;
        mac_start_s  = 1'b0;
        err_set_s    = 1'b0;
        acc_clr_s    = 1'b0;
        flush_s      = 1'b0;
        acc_load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (as_ok_s) begin
                    case (cp2.mem_cp2_wr_data[1:0])
                        2'b00: begin
                            if (count_r >= CNT_TWO) begin
                                mac_start_s  = 1'b1;
                                state_next_s = ST_MUL;
                            end else begin
                                err_set_s    = 1'b1;
                            end
                        end
                        2'b01:   acc_clr_s = 1'b1;
                        2'b10:   flush_s   = 1'b1;
                        default: state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (iter_r == ITER_LAST) begin
                    state_next_s = ST_ACC;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_ACC: begin
                acc_load_s   = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operand storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= cp2.mem_cp2_wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else if (flush_s) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r  <= wptr_r + PTR_ONE;
                count_r <= count_r + CNT_ONE;
            end else if (mac_start_s) begin
                rptr_r  <= rptr_r + PTR_TWO;
                count_r <= count_r - CNT_TWO;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Shift-add multiplier: A shifts left and B right, so b_sh_r[0] is B[i] and a_sh_r is A<<i
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_r    <= 32'd0;
            b_sh_r    <= 32'd0;
            product_r <= 32'd0;
            iter_r    <= '0;
        end else if (mac_start_s) begin
            a_sh_r    <= mem_r[rptr_r];
            b_sh_r    <= mem_r[rptr_r + PTR_ONE];
            product_r <= 32'd0;
            iter_r    <= '0;
        end else if (state_r == ST_MUL) begin
            a_sh_r    <= {a_sh_r[30:0], 1'b0};
            b_sh_r    <= {1'b0, b_sh_r[31:1]};
            product_r <= product_r + partial_s;
            iter_r    <= iter_r + ITER_ONE;
        end
    end

    // Accumulator and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= 32'd0;
            irq_r <= 1'b0;
        end else begin
            irq_r <= acc_load_s & cp2.cp_irenable_0;
            if (acc_clr_s) begin
                acc_r <= 32'd0;
            end else if (acc_load_s) begin
                acc_r <= acc_r + product_r;
            end
        end
    end

    assign cp2.cp2_fdata_0 = acc_r;
    assign cp2.cp2_busy    = busy_s;
    assign cp2.cp2_irq     = irq_r;
    assign cp2.cp2_count   = count_r;
    assign cp2.cp2_ovf     = ovf_r;
    assign cp2.cp2_err     = err_r;
endmodule

// File: tb/tb_cp2_mac_unit.sv
// Directed bench for cp2_mac_unit: hand-computed vectors for MAC, overflow,
// error/flush, busy stall, wrap/truncation and reset abort.
module tb_cp2_mac_unit;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cp2_mac_unit_if #(.FIFO_DEPTH(4)) bus ();

    cp2_mac_unit #(.FIFO_DEPTH(4), .MUL_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .cp2   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [31:0] d);
        bus.mem_en = 1'b1; bus.mem_cp2_ts_0 = 1'b1; bus.mem_cp2_wr_data = d;
        tick();
        bus.mem_en = 1'b0; bus.mem_cp2_ts_0 = 1'b0; bus.mem_cp2_wr_data = 32'd0;
    endtask

    task automatic do_as(input logic [1:0] op);
        bus.mem_en = 1'b1; bus.mem_cp2_as_0 = 1'b1; bus.mem_cp2_wr_data = {30'd0, op};
        tick();
        bus.mem_en = 1'b0; bus.mem_cp2_as_0 = 1'b0; bus.mem_cp2_wr_data = 32'd0;
    endtask

    // Leaves the bench in cycle N+34, where the new accumulator is visible
    task automatic mac(input logic [31:0] a, input logic [31:0] b);
        push(a);
        push(b);
        do_as(2'b00);
        wait_n(33);
    endtask

    function automatic logic [31:0] cnt();
        return {29'd0, bus.cp2_count};
    endfunction

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        bus.mem_en = 1'b0; bus.stall = 1'b0;
        bus.mem_cp2_ts_0 = 1'b0; bus.mem_cp2_as_0 = 1'b0; bus.mem_cp2_fs_0 = 1'b0;
        bus.mem_cp2_wr_data = 32'd0; bus.cp_irenable_0 = 1'b0;
        wait_n(3);
        reset = 1'b0;
        tick();
        chk("rst_fdata", bus.cp2_fdata_0, 32'd0);
        chk("rst_count", cnt(), 32'd0);
        chk("rst_busy", {31'd0, bus.cp2_busy}, 32'd0);
        chk("rst_irq", {31'd0, bus.cp2_irq}, 32'd0);
        chk("rst_ovf", {31'd0, bus.cp2_ovf}, 32'd0);
        chk("rst_err", {31'd0, bus.cp2_err}, 32'd0);

        // MAC 3*5 with IRQ enabled
        bus.cp_irenable_0 = 1'b1;
        push(32'd3);
        chk("t1_count1", cnt(), 32'd1);
        push(32'd5);
        chk("t1_count2", cnt(), 32'd2);
        do_as(2'b00);
        chk("t1_count0", cnt(), 32'd0);
        wait_n(32);
        chk("t1_irq_n33", {31'd0, bus.cp2_irq}, 32'd0);
        chk("t1_acc_n33", bus.cp2_fdata_0, 32'd0);
        tick();
        chk("t1_irq_n34", {31'd0, bus.cp2_irq}, 32'd1);
        chk("t1_acc_n34", bus.cp2_fdata_0, 32'd15);
        tick();
        chk("t1_irq_n35", {31'd0, bus.cp2_irq}, 32'd0);
        bus.mem_en = 1'b1; bus.mem_cp2_fs_0 = 1'b1;
        #1;
        chk("t1_fs_busy", {31'd0, bus.cp2_busy}, 32'd0);
        chk("t1_fs_data", bus.cp2_fdata_0, 32'd15);
        tick();
        bus.mem_en = 1'b0; bus.mem_cp2_fs_0 = 1'b0;

        // Overflow: 1..5 pushed, 5 dropped
        bus.cp_irenable_0 = 1'b0;
        do_as(2'b01);
        chk("t2_clr", bus.cp2_fdata_0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            push(32'(i));
            chk("t2_count", cnt(), (i > 4) ? 32'd4 : 32'(i));
            chk("t2_ovf", {31'd0, bus.cp2_ovf}, (i == 5) ? 32'd1 : 32'd0);
        end
        do_as(2'b00);
        chk("t2_pop1", cnt(), 32'd2);
        wait_n(33);
        chk("t2_acc1", bus.cp2_fdata_0, 32'd2);
        chk("t2_noirq", {31'd0, bus.cp2_irq}, 32'd0);
        do_as(2'b00);
        chk("t2_pop2", cnt(), 32'd0);
        wait_n(33);
        chk("t2_acc2", bus.cp2_fdata_0, 32'd14);
        chk("t2_ovf_sticky", {31'd0, bus.cp2_ovf}, 32'd1);

        // Error then flush
        do_as(2'b01);
        push(32'd7);
        do_as(2'b00);
        chk("t3_err", {31'd0, bus.cp2_err}, 32'd1);
        chk("t3_count", cnt(), 32'd1);
        wait_n(3);
        chk("t3_acc", bus.cp2_fdata_0, 32'd0);
        do_as(2'b10);
        chk("t3_flush_count", cnt(), 32'd0);
        chk("t3_flush_ovf", {31'd0, bus.cp2_ovf}, 32'd0);
        chk("t3_flush_err", {31'd0, bus.cp2_err}, 32'd0);

        // fs issued at N+5 while the 7*9 MAC runs
        push(32'd7);
        push(32'd9);
        do_as(2'b00);
        wait_n(4);
        bus.mem_en = 1'b1; bus.mem_cp2_fs_0 = 1'b1;
        for (int k = 5; k <= 33; k++) begin
            #1;
            chk("t4_busy", {31'd0, bus.cp2_busy}, 32'd1);
            tick();
        end
        #1;
        chk("t4_busy_n34", {31'd0, bus.cp2_busy}, 32'd0);
        chk("t4_read", bus.cp2_fdata_0, 32'd63);
        tick();
        bus.mem_en = 1'b0; bus.mem_cp2_fs_0 = 1'b0;
        bus.mem_cp2_as_0 = 1'b1; bus.mem_cp2_wr_data = 32'd1;
        tick();
        chk("t4_as_no_en", bus.cp2_fdata_0, 32'd63);
        bus.mem_en = 1'b1; bus.stall = 1'b1;
        tick();
        bus.mem_en = 1'b0; bus.stall = 1'b0; bus.mem_cp2_as_0 = 1'b0; bus.mem_cp2_wr_data = 32'd0;
        chk("t4_as_stalled", bus.cp2_fdata_0, 32'd63);

        // Wrap and truncation
        do_as(2'b01);
        mac(32'hFFFF_FFFF, 32'd1);
        chk("t5_max", bus.cp2_fdata_0, 32'hFFFF_FFFF);
        mac(32'd1, 32'd1);
        chk("t5_wrap", bus.cp2_fdata_0, 32'd0);
        mac(32'h0001_0000, 32'h0001_0000);
        chk("t5_trunc", bus.cp2_fdata_0, 32'd0);

        // Reset mid-MAC, with a ts pushed during MUL
        bus.cp_irenable_0 = 1'b1;
        mac(32'd2, 32'd3);
        chk("t6_pre_acc", bus.cp2_fdata_0, 32'd6);
        chk("t6_pre_irq", {31'd0, bus.cp2_irq}, 32'd1);
        push(32'd6);
        push(32'd6);
        do_as(2'b00);
        tick();
        push(32'd11);
        chk("t6_ts_in_mul", cnt(), 32'd1);
        wait_n(7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_acc", bus.cp2_fdata_0, 32'd0);
        chk("t6_count", cnt(), 32'd0);
        chk("t6_irq", {31'd0, bus.cp2_irq}, 32'd0);
        bus.mem_en = 1'b1; bus.mem_cp2_fs_0 = 1'b1;
        #1;
        chk("t6_idle_busy", {31'd0, bus.cp2_busy}, 32'd0);
        tick();
        bus.mem_en = 1'b0; bus.mem_cp2_fs_0 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk("t6_no_irq", {31'd0, bus.cp2_irq}, 32'd0);
            tick();
        end
        chk("t6_acc_final", bus.cp2_fdata_0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
